// File: rtl/scarv_soc_bram_bridge_pkg.sv
// ---------------------------------------------------------------------------
// scarv_soc_bram_bridge_pkg
//
// Shared types and helpers for the BRAM bridge:
//   rsp_entry_t    - one buffered response {rdata, error}
//   RSP_W          - packed width of rsp_entry_t
//   addr_in_range  - byte-address window check against [base, base+size)
// ---------------------------------------------------------------------------
package scarv_soc_bram_bridge_pkg;

  localparam int RSP_W = 33;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } rsp_entry_t;

  // Window check done in 33 bits so a BRAM mapped at the very top of the
  // address space cannot wrap its upper bound back to zero.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] size);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + size;
    return (a >= lo) && (a < hi);
  endfunction

endpackage

// File: rtl/scarv_soc_bram_bridge_fifo.sv
// ---------------------------------------------------------------------------
// scarv_soc_bram_bridge_fifo
//
// Small synchronous FIFO holding bridge responses. Head is presented
// combinationally on dout; pointers wrap modulo DEPTH (DEPTH need not be a
// power of two).
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (empties the FIFO)
//   push   in   write din this cycle (ignored when full)
//   din    in   entry to write
//   pop    in   drop head this cycle (ignored when empty)
//   dout   out  head entry
//   count  out  number of stored entries
//   full   out  count == DEPTH
//   empty  out  count == 0
// ---------------------------------------------------------------------------
module scarv_soc_bram_bridge_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/scarv_soc_bram_bridge.sv
// ---------------------------------------------------------------------------
// scarv_soc_bram_bridge
//
// Drives one port of the SoC dual-port BRAM from the valid/ready memory bus.
// Requests are range-checked and turned into BRAM strobes in the accept
// cycle; the read data comes back one cycle later and is pushed into a
// response FIFO so that a stalled consumer never loses it. Responses,
// including error responses, leave strictly in request order.
//
// Configuration macro:
//   SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN - when defined, misaligned
//   addresses (req_addr[1:0] != 0) produce an error response and leave the
//   BRAM untouched. When undefined, the low bits go to the BRAM unchanged.
//
// Parameters:
//   DEPTH      BRAM size in bytes (power of two)
//   BASE       byte address of BRAM byte 0 (DEPTH-aligned)
//   WRITE_EN   0 makes the port read-only; writes then report an error
//   RSP_DEPTH  response FIFO entries (>= 2, >= 3 for full throughput)
//
// Ports:
//   clka, rsta               clock, synchronous active-high reset
//   req_valid/ready          request handshake
//   req_addr/wen/strb/wdata  request payload
//   rsp_valid/ready          response handshake
//   rsp_rdata/error          response payload (rdata is 0 for writes/errors)
//   bram_en/we/addr/din      BRAM port strobes
//   bram_dout                BRAM read data, valid the cycle after bram_en
// ---------------------------------------------------------------------------
module scarv_soc_bram_bridge
  import scarv_soc_bram_bridge_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE      = 32'h0000_0000,
  parameter int          WRITE_EN  = 1,
  parameter int          RSP_DEPTH = 4,
  localparam int         LW        = $clog2(DEPTH)
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          req_wen,
  input  logic [3:0]    req_strb,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_error,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [LW-1:0] bram_addr,
  output logic [31:0]   bram_din,
  input  logic [31:0]   bram_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [RSP_W-1:0] head_bits;
  rsp_entry_t       head_entry;
  rsp_entry_t       push_entry;

  logic             inflight;
  logic             inflight_err;
  logic             inflight_wen;

  logic             fire;
  logic             align_ok;
  logic             write_ok;
  logic             access_ok;
  logic             pop;

  // A slot is reserved for every accepted request from acceptance until its
  // response is consumed, so the FIFO can never overflow. Only registered
  // state feeds this, never rsp_ready. The full term is implied by the sum
  // but keeps the FIFO status visible in the ready path.
  assign req_ready = !rsta && !fifo_full &&
                     ((32'(fifo_count) + 32'(inflight)) < 32'(RSP_DEPTH));
  assign fire      = req_valid && req_ready;

`ifdef SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN
  assign align_ok = (req_addr[1:0] == 2'b00);
`else
  assign align_ok = 1'b1;
`endif

  assign write_ok  = !req_wen || (WRITE_EN != 0);
  assign access_ok = addr_in_range(req_addr, BASE, 33'(DEPTH)) && align_ok && write_ok;

  // BRAM strobes are combinational in the accept cycle; a rejected request
  // never touches the BRAM. BASE is DEPTH-aligned, so the low LW bits of the
  // subtraction are all that matter.
  assign bram_en   = fire && access_ok;
  assign bram_we   = (bram_en && req_wen) ? req_strb : 4'b0000;
  assign bram_addr = req_addr[LW-1:0] - BASE[LW-1:0];
  assign bram_din  = req_wdata;

  // In-flight stage: remembers what the request one cycle ago was, so the
  // BRAM read data arriving now can be tagged correctly.
  always_ff @(posedge clka) begin
    if (rsta) begin
      inflight     <= 1'b0;
      inflight_err <= 1'b0;
      inflight_wen <= 1'b0;
    end else begin
      inflight     <= fire;
      inflight_err <= !access_ok;
      inflight_wen <= req_wen;
    end
  end

  // Only successful reads carry BRAM data; writes and errors return zero.
  always_comb begin
    push_entry       = '0;
    push_entry.error = inflight_err;
    if (!inflight_err && !inflight_wen)
      push_entry.rdata = bram_dout;
  end

  assign pop = rsp_valid && rsp_ready;

  scarv_soc_bram_bridge_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clka),
    .rst   (rsta),
    .push  (inflight),
    .din   (push_entry),
    .pop   (pop),
    .dout  (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head payload is forced to zero when nothing is buffered so the bus
  // never shows stale FIFO contents.
  assign head_entry = rsp_entry_t'(head_bits);
  assign rsp_valid  = !fifo_empty;
  assign rsp_rdata  = rsp_valid ? head_entry.rdata : 32'h0;
  assign rsp_error  = rsp_valid && head_entry.error;

endmodule

// File: tb/tb_scarv_soc_bram_bridge.sv
// ---------------------------------------------------------------------------
// tb_scarv_soc_bram_bridge
//
// Main DUT: DEPTH=1024, BASE=0, writable, RSP_DEPTH=4, attached to a
// behavioural BRAM. Second DUT: read-only port mapped at 0x1000 whose BRAM
// always returns a fixed word.
// ---------------------------------------------------------------------------
module tb_scarv_soc_bram_bridge;

  localparam int          DEPTH     = 1024;
  localparam int          RSP_DEPTH = 4;
  localparam logic [31:0] ROM_BASE  = 32'h0000_1000;
  localparam logic [31:0] ROM_WORD  = 32'hC0DE_F00D;

  logic        clka = 1'b0;
  logic        rsta;

  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din, bram_dout;

  logic        rom_req_valid, rom_req_ready, rom_req_wen;
  logic [31:0] rom_req_addr, rom_req_wdata;
  logic [3:0]  rom_req_strb;
  logic        rom_rsp_valid, rom_rsp_error;
  logic [31:0] rom_rsp_rdata;
  logic        rom_bram_en;
  logic [3:0]  rom_bram_we;
  logic [9:0]  rom_bram_addr;
  logic [31:0] rom_bram_din;
  logic [31:0] rom_bram_dout;

  int checks   = 0;
  int failures = 0;
  int stalls   = 0;

  always #5 clka = ~clka;

  scarv_soc_bram_bridge #(
    .DEPTH(DEPTH), .BASE(32'h0), .WRITE_EN(1), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clka(clka), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_strb(req_strb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  scarv_soc_bram_bridge #(
    .DEPTH(DEPTH), .BASE(ROM_BASE), .WRITE_EN(0), .RSP_DEPTH(RSP_DEPTH)
  ) rom_dut (
    .clka(clka), .rsta(rsta),
    .req_valid(rom_req_valid), .req_ready(rom_req_ready), .req_addr(rom_req_addr),
    .req_wen(rom_req_wen), .req_strb(rom_req_strb), .req_wdata(rom_req_wdata),
    .rsp_valid(rom_rsp_valid), .rsp_ready(1'b1), .rsp_rdata(rom_rsp_rdata),
    .rsp_error(rom_rsp_error),
    .bram_en(rom_bram_en), .bram_we(rom_bram_we), .bram_addr(rom_bram_addr),
    .bram_din(rom_bram_din), .bram_dout(rom_bram_dout)
  );

  assign rom_bram_dout = ROM_WORD;

  // Behavioural BRAM for the main port: read-first, one-cycle read latency.
  logic [31:0] bmem [256];
  always @(posedge clka) begin
    if (bram_en) begin
      bram_dout <= bmem[bram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) bmem[bram_addr[9:2]][8*b +: 8] <= bram_din[8*b +: 8];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: every accepted request becomes one expected response,
  // computed from a golden memory at acceptance time, released two cycles
  // later and retired on handshake. Outstanding requests bound readiness.
  // ------------------------------------------------------------------------
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        mq[$];
  logic [32:0] rsp_log[$];
  logic [31:0] gmem [256];
  int          cyc = 0;
  logic        prev_rst = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_rdata = '0;
  logic        prev_err = 1'b0;

  function automatic logic model_ok(input logic [31:0] a);
    logic ok;
    ok = (a < 32'(DEPTH));
`ifdef SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

  always @(negedge clka) begin : compare
    logic exp_ready, fire, ok, exp_valid;
    exp_t e;
    cyc++;
    exp_ready = !rsta && (mq.size() < RSP_DEPTH);
    fire      = req_valid && exp_ready;
    ok        = model_ok(req_addr);
    checkOutput("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    checkOutput("bram_en", {31'b0, bram_en}, {31'b0, fire && ok});
    checkOutput("bram_we", {28'b0, bram_we}, (fire && ok && req_wen) ? {28'b0, req_strb} : 32'h0);
    checkOutput("bram_addr", {22'b0, bram_addr}, {22'b0, req_addr[9:0]});
    checkOutput("bram_din", bram_din, req_wdata);

    exp_valid = (mq.size() > 0) && (mq[0].cyc + 2 <= cyc);
    if (!(rsta && !prev_rst)) begin
      checkOutput("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        checkOutput("rsp_rdata", rsp_rdata, mq[0].rdata);
        checkOutput("rsp_error", {31'b0, rsp_error}, {31'b0, mq[0].err});
      end
      if (rsta) begin
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("rst_rsp_error", {31'b0, rsp_error}, 32'h0);
      end
    end
    if (prev_stall && !rsta) begin
      checkOutput("stall_valid", {31'b0, rsp_valid}, 32'h1);
      checkOutput("stall_rdata", rsp_rdata, prev_rdata);
      checkOutput("stall_error", {31'b0, rsp_error}, {31'b0, prev_err});
    end
    prev_stall = rsp_valid && !rsp_ready && !rsta;
    prev_rdata = rsp_rdata;
    prev_err   = rsp_error;
    prev_rst   = rsta;

    if (rsta) begin
      mq.delete();
    end else begin
      if (exp_valid && rsp_ready) begin
        rsp_log.push_back({rsp_rdata, rsp_error});
        void'(mq.pop_front());
      end
      if (fire) begin
        e.cyc = cyc;
        e.err = !ok;
        e.rdata = 32'h0;
        if (ok && req_wen) begin
          for (int b = 0; b < 4; b++)
            if (req_strb[b]) gmem[req_addr[9:2]][8*b +: 8] = req_wdata[8*b +: 8];
        end else if (ok) begin
          e.rdata = gmem[req_addr[9:2]];
        end
        mq.push_back(e);
      end
    end
  end

  // Offer one request from posedge+1 and hold it until accepted.
  task automatic applyStimulus(input logic [31:0] a, input logic w,
                               input logic [3:0] s, input logic [31:0] d);
    int guard;
    guard     = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wen   = w;
    req_strb  = s;
    req_wdata = d;
    @(negedge clka);
    while (!req_ready && guard < 50) begin
      stalls++;
      guard++;
      @(negedge clka);
    end
    if (!req_ready) checkOutput("accept_timeout", 32'h0, 32'h1);
    @(posedge clka);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (mq.size() != 0 && guard < 100) begin
      @(posedge clka);
      #1;
      guard++;
    end
    checkOutput("drain_empty", 32'(mq.size()), 32'h0);
  endtask

  task automatic checkLog(input string name, input int idx,
                          input logic [31:0] rd, input logic err);
    if (idx >= rsp_log.size()) begin
      checkOutput({name, "_missing"}, 32'(rsp_log.size()), 32'(idx + 1));
    end else begin
      checkOutput({name, "_rdata"}, rsp_log[idx][32:1], rd);
      checkOutput({name, "_error"}, {31'b0, rsp_log[idx][0]}, {31'b0, err});
    end
  endtask

  task automatic romAccess(input string name, input logic w, input logic [31:0] a,
                           input logic exp_en, input logic [9:0] exp_ba,
                           input logic [31:0] exp_rd, input logic exp_err);
    int g;
    rom_req_valid = 1'b1;
    rom_req_addr  = a;
    rom_req_wen   = w;
    rom_req_strb  = 4'hF;
    rom_req_wdata = 32'h5555_AAAA;
    @(negedge clka);
    checkOutput({name, "_ready"}, {31'b0, rom_req_ready}, 32'h1);
    checkOutput({name, "_en"}, {31'b0, rom_bram_en}, {31'b0, exp_en});
    checkOutput({name, "_we"}, {28'b0, rom_bram_we}, 32'h0);
    if (exp_en) checkOutput({name, "_addr"}, {22'b0, rom_bram_addr}, {22'b0, exp_ba});
    @(posedge clka);
    #1;
    rom_req_valid = 1'b0;
    g = 0;
    @(negedge clka);
    while (!rom_rsp_valid && g < 8) begin
      @(negedge clka);
      g++;
    end
    checkOutput({name, "_rsp_valid"}, {31'b0, rom_rsp_valid}, 32'h1);
    checkOutput({name, "_latency"}, 32'(g), 32'h1);
    checkOutput({name, "_rdata"}, rom_rsp_rdata, exp_rd);
    checkOutput({name, "_error"}, {31'b0, rom_rsp_error}, {31'b0, exp_err});
    @(posedge clka);
    #1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lg;
    int sel;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      bmem[i] = '0;
      gmem[i] = '0;
    end
    rsta = 1'b1;
    req_valid = 0; req_addr = 0; req_wen = 0; req_strb = 0; req_wdata = 0;
    rsp_ready = 1'b1;
    rom_req_valid = 0; rom_req_addr = 0; rom_req_wen = 0; rom_req_strb = 0; rom_req_wdata = 0;
    @(negedge clka);
    checkOutput("reset_req_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clka); @(posedge clka); @(posedge clka);
    #1;
    rsta = 1'b0;
    @(negedge clka);
    checkOutput("post_reset_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clka);
    #1;

    // Back-to-back stream after a write
    $display("[TB] back-to-back stream");
    stalls = 0;
    lg = rsp_log.size();
    applyStimulus(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
    applyStimulus(32'h10, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h14, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h18, 1'b0, 4'h0, 32'h0);
    checkOutput("b2b_stalls", 32'(stalls), 32'h0);
    drain();
    checkLog("b2b_write", lg, 32'h0, 1'b0);
    checkLog("b2b_read10", lg + 1, 32'hDEAD_BEEF, 1'b0);

    // Byte strobes
    $display("[TB] byte strobes");
    lg = rsp_log.size();
    applyStimulus(32'h20, 1'b1, 4'hF, 32'h1122_3344);
    applyStimulus(32'h20, 1'b1, 4'b0100, 32'hAABB_CCDD);
    applyStimulus(32'h20, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h24, 1'b1, 4'h0, 32'hFFFF_FFFF);
    applyStimulus(32'h24, 1'b0, 4'h0, 32'h0);
    drain();
    checkLog("strb_read", lg + 2, 32'h11BB_3344, 1'b0);
    checkLog("strb_zero_wr", lg + 3, 32'h0, 1'b0);
    checkLog("strb_zero_rd", lg + 4, 32'h0, 1'b0);

    // Back-pressure: only RSP_DEPTH requests can be outstanding
    $display("[TB] back-pressure");
    rsp_ready = 1'b0;
    lg = rsp_log.size();
    applyStimulus(32'h10, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h20, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h10, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h20, 1'b0, 4'h0, 32'h0);
    req_valid = 1'b1; req_addr = 32'h14; req_wen = 1'b0;
    repeat (4) begin
      @(negedge clka);
      checkOutput("bp_full_ready", {31'b0, req_ready}, 32'h0);
    end
    @(posedge clka);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    checkOutput("bp_count", 32'(rsp_log.size() - lg), 32'h4);
    checkLog("bp_rsp0", lg,     32'hDEAD_BEEF, 1'b0);
    checkLog("bp_rsp1", lg + 1, 32'h11BB_3344, 1'b0);
    checkLog("bp_rsp2", lg + 2, 32'hDEAD_BEEF, 1'b0);
    checkLog("bp_rsp3", lg + 3, 32'h11BB_3344, 1'b0);

    // Error responses stay in order with normal ones
    $display("[TB] errors");
    lg = rsp_log.size();
    applyStimulus(32'h400, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h404, 1'b1, 4'hF, 32'h1234_5678);
    applyStimulus(32'h12, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h3FC, 1'b0, 4'h0, 32'h0);
    drain();
    checkLog("err_read_top", lg, 32'h0, 1'b1);
    checkLog("err_write_top", lg + 1, 32'h0, 1'b1);
`ifdef SCARV_SOC_BRAM_BRIDGE_ALIGN_CHECK_EN
    checkLog("err_unaligned", lg + 2, 32'h0, 1'b1);
`else
    checkLog("unaligned_read", lg + 2, 32'hDEAD_BEEF, 1'b0);
`endif
    checkLog("last_word", lg + 3, 32'h0, 1'b0);

    // Simultaneous push/pop with two buffered responses
    $display("[TB] push/pop");
    rsp_ready = 1'b0;
    lg = rsp_log.size();
    applyStimulus(32'h10, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h20, 1'b0, 4'h0, 32'h0);
    @(posedge clka); @(posedge clka);
    #1;
    rsp_ready = 1'b1;
    stalls = 0;
    for (int i = 0; i < 10; i++)
      applyStimulus((i % 2 == 0) ? 32'h10 : 32'h20, 1'b0, 4'h0, 32'h0);
    checkOutput("pp_stalls", 32'(stalls), 32'h0);
    drain();
    checkOutput("pp_count", 32'(rsp_log.size() - lg), 32'd12);
    checkLog("pp_first", lg, 32'hDEAD_BEEF, 1'b0);
    checkLog("pp_last", lg + 11, 32'h11BB_3344, 1'b0);

    // Reset in the middle of outstanding reads
    $display("[TB] mid-burst reset");
    rsp_ready = 1'b0;
    applyStimulus(32'h10, 1'b0, 4'h0, 32'h0);
    applyStimulus(32'h14, 1'b0, 4'h0, 32'h0);
    req_valid = 1'b1; req_addr = 32'h10; req_wen = 1'b0;
    rsta = 1'b1;
    repeat (3) begin
      @(negedge clka);
      checkOutput("rst_ready", {31'b0, req_ready}, 32'h0);
      checkOutput("rst_bram_en", {31'b0, bram_en}, 32'h0);
    end
    @(posedge clka);
    #1;
    rsta = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clka);
    checkOutput("rst_release_ready", {31'b0, req_ready}, 32'h1);
    repeat (4) begin
      checkOutput("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
      @(negedge clka);
    end
    @(posedge clka);
    #1;

    // Randomised traffic
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 19));
      if (sel < 14)      a = 32'h40 + 32'($urandom_range(0, 15) << 2);
      else if (sel < 16) a = 32'h40 + 32'($urandom_range(0, 63));
      else if (sel < 18) a = 32'h400 + 32'($urandom_range(0, 255) << 2);
      else               a = $urandom;
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = a;
      req_wen   = ($urandom_range(0, 2) == 0);
      req_strb  = 4'($urandom);
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clka);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Read-only port mapped at ROM_BASE
    $display("[TB] read-only port");
    romAccess("rom_write", 1'b1, ROM_BASE, 1'b0, 10'h0, 32'h0, 1'b1);
    romAccess("rom_read", 1'b0, ROM_BASE + 32'h4, 1'b1, 10'h004, ROM_WORD, 1'b0);
    romAccess("rom_below", 1'b0, ROM_BASE - 32'h4, 1'b0, 10'h0, 32'h0, 1'b1);
    romAccess("rom_top", 1'b0, ROM_BASE + 32'h3FC, 1'b1, 10'h3FC, ROM_WORD, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
